irq_receiver: RTL

IRQ_RECEIVER -- requirements
Module: irq_receiver

---
 rtl/irq_receiver_pkg.sv | 26 ++
 rtl/irq_sync.sv | 26 ++
 rtl/irq_receiver.sv | 96 +++++++++
 3 files changed

// File: rtl/irq_receiver_pkg.sv
// Shared types and helpers for the interrupt receiver.
package irq_receiver_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_e;

   // Width of the delivered interrupt id, never narrower than one bit.
   function automatic int id_width(input int w);
      int r;
      r = $clog2(w);
      return (r < 1) ? 1 : r;
   endfunction

   // Index of the lowest set bit; returns 0 when no bit is set.
   function automatic logic [5:0] lowest_set(input logic [63:0] v);
      logic [5:0] idx;
      idx = '0;
      for (int unsigned i = 64; i > 0; i--) begin
         if (v[i-1]) idx = 6'(i - 1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for asynchronous interrupt lines.
module irq_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];

   // Shift the raw lines through the synchronizer chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= i_d;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_receiver.sv
// Interrupt receiver: synchronizes lines, latches pending bits and
// delivers the lowest-index enabled interrupt over a valid/ready handshake.
module irq_receiver
   import irq_receiver_pkg::*;
#(
   parameter  int WIDTH       = 8,
   parameter  int SYNC_STAGES = 2,
   localparam int ID_W        = id_width(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_irq,
   input  logic [WIDTH-1:0] i_edge_mode,
   input  logic [WIDTH-1:0] i_mask,
   output logic [WIDTH-1:0] o_pending,
   output logic             o_irq,
   output logic             o_irq_valid,
   output logic [ID_W-1:0]  o_irq_id,
   input  logic             i_irq_ready
);

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] s_prev_q;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] active;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] set_ev;
   logic [WIDTH-1:0] clr;
   logic             hs;
   state_e           state_q, state_d;
   logic [ID_W-1:0]  id_q, id_d;

   irq_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_irq),
      .o_q     (s)
   );

   // Set/clear evaluation for the pending register.
   // Edge sets override a same-cycle clear; a level line is dropped for the
   // clear cycle and re-pends on the following one while still high.
   always_comb begin
      active = pending_q & i_mask;
      hs     = (state_q == PRESENT) && i_irq_ready;
      clr    = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         clr[i] = hs && (id_q == ID_W'(i));
      end
      rise      = s & ~s_prev_q;
      set_ev    = (i_edge_mode & rise) | (~i_edge_mode & s & ~clr);
      pending_d = (pending_q & ~clr) | set_ev;
   end

   // Delivery FSM: pick lowest enabled pending line, hold until accepted.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (|active) begin
               id_d    = ID_W'(lowest_set(64'(active)));
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (i_irq_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, id, pending and edge-history registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         id_q      <= '0;
         pending_q <= '0;
         s_prev_q  <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         pending_q <= pending_d;
         s_prev_q  <= s;
      end
   end

   assign o_pending   = pending_q;
   assign o_irq       = |active;
   assign o_irq_valid = (state_q == PRESENT);
   assign o_irq_id    = id_q;

endmodule
